// File: rtl/cond_pipe_if.sv
// cond_pipe_if: request/result handshake bundle between register-read and PC-select.
interface cond_pipe_if #(
   parameter int WIDTH     = 32,
   parameter int OUT_WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          Op_code;
   logic [WIDTH-1:0]     Addr_1;
   logic [WIDTH-1:0]     Addr_2;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] Output;
   modport master (
      output in_valid, Op_code, Addr_1, Addr_2, out_ready,
      input  in_ready, out_valid, Output
   );
   modport slave (
      input  in_valid, Op_code, Addr_1, Addr_2, out_ready,
      output in_ready, out_valid, Output
   );
endinterface

// File: rtl/cond_pipe.sv
// cond_pipe: two-stage branch-condition evaluator with saved flags and a saturating taken counter.
module cond_pipe #(
   parameter int WIDTH     = 32,
   parameter int OUT_WIDTH = 16,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   cond_pipe_if.slave           bus,
   input  logic                 cnt_clear,
   output logic [CNT_WIDTH-1:0] taken_count
);
   localparam logic [7:0] C_FLAGS = 8'd14;
   logic [WIDTH-1:0]     a, b;
   logic [7:0]           code, s1_code;
   logic [3:0]           sub;
   logic [4:0]           cur_f, saved_f, s1_f;
   logic                 s1_valid, out_valid_q, adv1, adv2, is_flags, accept, unused_op;
   logic [OUT_WIDTH-1:0] out_q;
   assign a         = bus.Addr_1;
   assign b         = bus.Addr_2;
   assign code      = bus.Op_code[7:0];
   assign sub       = bus.Op_code[11:8];
   assign unused_op = ^bus.Op_code[31:12];
   assign is_flags  = code == C_FLAGS;
   // flag order {eq, ltu, lts, za, bt}
   assign cur_f = {a == b, a < b, $signed(a) < $signed(b), a == '0, (a & b) != '0};
   assign adv2         = !out_valid_q || bus.out_ready;
   assign adv1         = !s1_valid || adv2;
   assign bus.in_ready = adv1 && !rst;
   assign accept       = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.Output    = out_q;
   function automatic logic decode(input logic [7:0] c, input logic [4:0] f);
      case (c)
         8'd0:    return f[4];
         8'd1:    return !f[4];
         8'd2:    return f[3];
         8'd3:    return f[3] | f[4];
         8'd4:    return !(f[3] | f[4]);
         8'd5:    return !f[3];
         8'd6:    return f[2];
         8'd7:    return f[2] | f[4];
         8'd8:    return !(f[2] | f[4]);
         8'd9:    return !f[2];
         8'd10:   return f[1];
         8'd11:   return !f[1];
         8'd12:   return f[0];
         8'd13:   return !f[0];
         8'd15:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_f        <= '0;
         s1_code     <= '0;
         saved_f     <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         if (adv1) s1_valid <= bus.in_valid;
         if (accept) begin
            s1_f <= is_flags ? saved_f : cur_f;
            // FLAGS sub-codes 14/15 are remapped to an undefined code so they yield 0, not ALWAYS
            s1_code <= is_flags ? ((sub < 4'd14) ? {4'b0, sub} : 8'hFF) : code;
            if (!is_flags) saved_f <= cur_f;
         end
         if (adv2) out_valid_q <= s1_valid;
         if (adv2 && s1_valid) out_q <= {{(OUT_WIDTH-1){1'b0}}, decode(s1_code, s1_f)};
      end
   end
   always_ff @(posedge clk) begin
      if (rst || cnt_clear) taken_count <= '0;
      else if (out_valid_q && bus.out_ready && out_q[0] && !(&taken_count))
         taken_count <= taken_count + CNT_WIDTH'(1);
   end
endmodule

// File: tb/tb_cond_pipe.sv
// tb_cond_pipe: directed + random stimulus against an operand-level reference model.
module tb_cond_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cnt_clear = 1'b0;
   logic [3:0] taken_count;
   int checks = 0;
   int errors = 0;
   bit res_q[$];
   int age_q[$];
   logic [31:0] sa = 32'd1, sb = 32'd0;
   int cnt_m = 0;
   always #5 clk = ~clk;
   cond_pipe_if #(.WIDTH(32), .OUT_WIDTH(16)) bus ();
   cond_pipe #(.WIDTH(32), .OUT_WIDTH(16), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .bus(bus), .cnt_clear(cnt_clear), .taken_count(taken_count)
   );
   function automatic bit ref_c(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         8'd0:    return a == b;
         8'd1:    return a != b;
         8'd2:    return a < b;
         8'd3:    return a <= b;
         8'd4:    return a > b;
         8'd5:    return a >= b;
         8'd6:    return $signed(a) < $signed(b);
         8'd7:    return $signed(a) <= $signed(b);
         8'd8:    return $signed(a) > $signed(b);
         8'd9:    return $signed(a) >= $signed(b);
         8'd10:   return a == 0;
         8'd11:   return a != 0;
         8'd12:   return (a & b) != 0;
         8'd13:   return (a & b) == 0;
         8'd15:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cycle(input bit v, input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit ordy, input bit clr, input bit r, output bit acc);
      bit exp_rdy, exp_ov, res;
      @(negedge clk);
      bus.in_valid = v; bus.Op_code = op; bus.Addr_1 = a; bus.Addr_2 = b;
      bus.out_ready = ordy; cnt_clear = clr; rst = r;
      #1;
      exp_rdy = !r && (res_q.size() < 2 || ordy);
      exp_ov  = res_q.size() == 2 || (res_q.size() == 1 && age_q[0] >= 2);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (exp_ov) chk("Output", 32'(bus.Output), 32'(res_q[0]));
      chk("taken_count", 32'(taken_count), 32'(cnt_m));
      acc = v && exp_rdy;
      if (r) begin
         res_q.delete(); age_q.delete(); sa = 32'd1; sb = 32'd0; cnt_m = 0;
      end else begin
         if (exp_ov && ordy) begin
            res = res_q.pop_front();
            void'(age_q.pop_front());
            if (res && cnt_m < 15) cnt_m++;
         end
         if (clr) cnt_m = 0;
         if (acc) begin
            // reset flags are all-zero, which the operand pair (1,0) reproduces
            if (op[7:0] == 8'd14) res = (op[11:8] < 4'd14) ? ref_c({4'b0, op[11:8]}, sa, sb) : 1'b0;
            else begin
               res = ref_c(op[7:0], a, b); sa = a; sb = b;
            end
            res_q.push_back(res); age_q.push_back(0);
         end
      end
      foreach (age_q[i]) age_q[i]++;
   endtask
   task automatic send(input bit v, input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
      bit acc;
      cycle(v, op, a, b, 1'b1, 1'b0, 1'b0, acc);
   endtask
   initial begin
      bit acc;
      int k;
      logic [31:0] ra, rb, rop;
      bus.in_valid = 0; bus.Op_code = 0; bus.Addr_1 = 0; bus.Addr_2 = 0; bus.out_ready = 1;
      @(posedge clk);
      cycle(0, 0, 0, 0, 1, 0, 1, acc);
      for (int c = 0; c < 10; c++) send(1, 32'(c), 32'hFFFF_FFFF, 32'd1);
      for (int c = 0; c < 10; c++) send(1, 32'(c), 32'd5, 32'd5);
      repeat (3) send(0, 0, 0, 0);
      send(1, 32'd10, 0, 3); send(1, 32'd11, 0, 3); send(1, 32'd12, 0, 3); send(1, 32'd13, 0, 3);
      send(1, 32'd12, 6, 3); send(1, 32'd15, $urandom, $urandom); send(1, 32'h40, 7, 7);
      send(1, 32'd6, 1, 2); send(1, 32'h080E, 0, 0); send(1, 32'h060E, 9, 9);
      send(1, 32'h0F0E, 0, 0); send(1, 32'hABCD_F10F, 0, 0);
      repeat (3) send(0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0, 1, acc);
      send(1, 32'h010E, 7, 7);
      repeat (3) send(0, 0, 0, 0);
      k = 0;
      repeat (5) begin
         cycle(k < 4, 32'(k), 32'(k), 32'd1, 0, 0, 0, acc);
         if (acc) k++;
      end
      chk("bp_accepts", 32'(k), 32'd2);
      for (int n = 0; n < 8; n++) begin
         cycle(k < 4, 32'(k), 32'(k), 32'd1, 1, 0, 0, acc);
         if (acc) k++;
      end
      chk("bp_total", 32'(k), 32'd4);
      repeat (20) send(1, 32'd15, 0, 0);
      repeat (3) send(0, 0, 0, 0);
      chk("cnt_sat", 32'(taken_count), 32'd15);
      send(1, 32'd15, 0, 0); send(0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 1, 0, acc);
      send(0, 0, 0, 0);
      chk("cnt_clear_hs", 32'(taken_count), 32'd0);
      cycle(1, 32'd15, 0, 0, 0, 0, 0, acc);
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, acc);
      chk("cnt_unconsumed", 32'(taken_count), 32'd0);
      repeat (3) send(1, 32'd15, 0, 0);
      repeat (3) send(0, 0, 0, 0);
      cycle(1, 32'd15, 0, 0, 0, 0, 0, acc);
      cycle(1, 32'd15, 0, 0, 0, 0, 0, acc);
      cycle(1, 32'd15, 0, 0, 0, 0, 1, acc);
      send(0, 0, 0, 0);
      chk("rst_cnt", 32'(taken_count), 32'd0);
      send(1, 32'h000E, 3, 3);
      repeat (3) send(0, 0, 0, 0);
      repeat (400) begin
         rb  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 4)) : $urandom;
         ra  = ($urandom_range(0, 3) == 0) ? rb : (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 4)) : $urandom);
         rop = {$urandom_range(0, 65535), 4'($urandom_range(0, 15)), 4'd0, 8'd0};
         rop[7:0] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         cycle($urandom_range(0, 3) != 0, rop, ra, rb, $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0, acc);
      end
      repeat (4) send(0, 0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cond_pipe.md
# cond_pipe

Pipelined, parametrised branch-condition evaluator for the pumpeds datapath. Compares two operands under an opcode-selected relation and returns 1 or 0 zero-extended to OUT_WIDTH. Adds valid/ready flow control, a saved-flags register so later instructions can re-test an earlier comparison, zero and bit-test modes, and a saturating taken-branch counter. Sits between the register-read stage and the PC-select logic.

## Interface
- WIDTH, 32, operand width in bits (≥2)
- OUT_WIDTH, 16, result width; bit 0 carries the condition, upper bits are 0
- CNT_WIDTH, 32, width of the taken counter
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready
- Op_code  in  32  bits [7:0] select the condition; bits [11:8] are the sub-condition for FLAGS; all other bits are ignored
- Addr_1  in  WIDTH  operand A
- Addr_2  in  WIDTH  operand B
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- Output  out  OUT_WIDTH  result
- cnt_clear  in  1  zero the taken counter
- taken_count  out  CNT_WIDTH  number of consumed results equal to 1, saturating

## Operation
- Condition codes, selected by Op_code[7:0]:
  - 0 EQ: A==B
  - 1 NE
  - 2 LTU: A<B unsigned
  - 3 LEU
  - 4 GTU
  - 5 GEU
  - 6 LT: signed two's complement
  - 7 LE
  - 8 GT
  - 9 GE
  - 10 ZERO: A==0
  - 11 NZ
  - 12 BSET: (A&B)!=0
  - 13 BCLR: (A&B)==0
  - 14 FLAGS
  - 15 ALWAYS: 1
  - 16..255: result 0
- Flag vector: eq, ltu, lts, za, bt. All five are computed combinationally from A and B in stage 1. Codes 0-13 are decoded from these flags.
- Saved-flags register:
  - Loads the flag vector whenever a request with code ≠14 is accepted.
  - A code-14 request does not load it.
  - Reset value is all 0.
- FLAGS (code 14):
  - Stage 1 captures the saved-flags register instead of A/B flags.
  - Op_code[11:8] (values 0-13) is decoded against those flags using the table above.
  - Sub-codes 14 and 15 give result 0.
  - With reset flags: sub-code EQ gives 0 and NE gives 1.
- Pipeline:
  - S1 registers the selected flag vector, the decode code and s1_valid.
  - S2 registers Output and out_valid.
- Advance rules:
  - adv2 = !out_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 && !rst
- Taken counter:
  - Increments by 1 on each output handshake with Output[0]=1.
  - Holds at all-ones (saturates).
  - cnt_clear has priority and sets it to 0 in that cycle, even if a handshake occurs in the same cycle.
- Reset: out_valid=0, Output=0, s1_valid=0, saved flags=0, taken_count=0. Any request in flight is dropped.

## Timing
- Latency: accepted at edge N gives out_valid=1 with the result after edge N+1, assuming no stall.
- Throughput: 1 result per cycle while out_ready=1.
- out_ready low with both stages full:
  - in_ready=0.
  - Output and out_valid hold stable.
  - The saved-flags register does not change.
- Back-to-back compare then FLAGS in consecutive cycles: the FLAGS request sees that compare's flags, with no bubble.
- Output changes only on an edge where adv2=1.
- Output is not forced to 0 when out_valid=0; consumers must ignore it.
- in_ready is combinational from out_ready. There is no combinational path from in_valid to out_valid.
- rst asserted mid-stream: after that edge, out_valid=0 and in_ready=0 while rst stays high. in_ready returns to 1 in the first cycle with rst low.

## Test plan
- Relational sweep, WIDTH=32, out_ready=1:
  - A=0xFFFFFFFF, B=1: codes 0-9 give 0,1,0,0,1,1,1,1,0,0.
  - A=B=5: codes 0-9 give 1,0,0,1,0,1,0,1,0,1.
  - Each result appears 2 cycles after acceptance.
- Zero/bit modes:
  - A=0, B=3: code 10→1, 11→0, 12→0, 13→1.
  - A=6, B=3: code 12→1.
  - Code 15→1 for any operands; code 0x40→0.
- FLAGS:
  - Code 6 with A=1, B=2, then code 14 with Op_code[11:8]=8 next cycle: outputs 1, then 0.
  - A second code 14 with sub-code 6 gives 1, because flags are unchanged.
  - Code 14 directly after reset with sub-code 1 gives 1.
- Backpressure:
  - Issue 4 requests, hold out_ready=0 for 5 cycles: in_ready drops after 2 accepts and Output stays on request 1.
  - Release out_ready: results 1-4 appear in order, none lost or duplicated.
- Counter, CNT_WIDTH=4:
  - 20 consumed results of 1 saturate taken_count at 15.
  - cnt_clear in the same cycle as a taken handshake gives 0.
  - Results that are valid but not consumed do not count.
- Reset mid-operation:
  - Assert rst with both stages full: out_valid=0 and taken_count=0 next cycle.
  - A code 14 sub-code 0 request after reset gives 0.
